alu_sched: RTL and testbench

//   Round-robin scheduler sharing one 8-bit registered ALU (1-cycle latency, opcodes 0-7) among NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/alu_sched.sv | 147 ++++++++++++++
 tb/tb_alu_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU scheduler slice:
//   opcode_e      - 3-bit ALU opcode encoding (0..7)
//   sched_state_e - scheduler FSM states
//   alu_model     - behavioural reference of the 8-bit ALU result, used by
//                   scoreboards and by simulation-side ALU stand-ins
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int OP_W  = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_NOT  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_NAND = 3'd6,
        OP_NOR  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } sched_state_e;

    // Wrap-around 8-bit ALU; no carry or borrow is exported.
    function automatic logic [ALU_W-1:0] alu_model(input logic [ALU_W-1:0] a,
                                                   input logic [ALU_W-1:0] b,
                                                   input opcode_e          op);
        logic [ALU_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            default: r = {ALU_W{1'b0}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of req found by
// scanning upward from ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  ID_W     index with highest priority this cycle
//   gnt_onehot out NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx    out ID_W     index of the granted requester (0 when none)
//   gnt_any    out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    // ptr + off modulo NUM_REQ; off < NUM_REQ so a single subtract suffices,
    // which also keeps non-power-of-two NUM_REQ correct.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p,
                                                 input int              off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return ID_W'(s);
    endfunction

    // Priority scan starting at ptr; the first hit wins.
    always_comb begin
        gnt_onehot = {NUM_REQ{1'b0}};
        gnt_idx    = {ID_W{1'b0}};
        gnt_any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req[wrap_idx(ptr, i)]) begin
                gnt_any                        = 1'b1;
                gnt_idx                        = wrap_idx(ptr, i);
                gnt_onehot[wrap_idx(ptr, i)]   = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
// Round-robin scheduler sharing one registered 8-bit ALU (1-cycle latency)
// among NUM_REQ requesters. One operation is in flight at a time:
//   IDLE -> EXEC -> CAPT -> RESP -> IDLE
// Ports:
//   clk_i, rst_n_i              clock / async active-low reset
//   req_valid_i, req_ready_o    per-requester handshake (ready is one-hot or 0)
//   req_a_i, req_b_i, req_op_i  packed per-requester operands / opcode
//   rsp_valid_o, rsp_ready_i    response handshake
//   rsp_id_o, rsp_result_o      requester index and ALU result
//   alu_a_o, alu_b_o,
//   alu_opcode_o                registered ALU inputs (hold last issue)
//   alu_result_i                registered ALU output
// -----------------------------------------------------------------------------
module alu_sched
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*3-1:0]  req_op_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [DATA_W-1:0]     rsp_result_o,
    output logic [DATA_W-1:0]     alu_a_o,
    output logic [DATA_W-1:0]     alu_b_o,
    output logic [2:0]            alu_opcode_o,
    input  logic [DATA_W-1:0]     alu_result_i
);

    sched_state_e        state_r;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     id_r;

    logic [NUM_REQ-1:0]  gnt_onehot_s;
    logic [ID_W-1:0]     gnt_idx_s;
    logic                gnt_any_s;
    logic [ID_W-1:0]     ptr_next_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic [2:0]          sel_op_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid_i),
        .ptr        (ptr_r),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .gnt_any    (gnt_any_s)
    );

    // Ready only in IDLE and never while reset is held.
    always_comb begin
        if (rst_n_i && (state_r == IDLE)) begin
            req_ready_o = gnt_onehot_s;
        end else begin
            req_ready_o = {NUM_REQ{1'b0}};
        end
    end

    // Operand mux driven by the one-hot grant (constant part-select bases).
    always_comb begin
        sel_a_s  = {DATA_W{1'b0}};
        sel_b_s  = {DATA_W{1'b0}};
        sel_op_s = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_onehot_s[k]) begin
                sel_a_s  = req_a_i[k*DATA_W +: DATA_W];
                sel_b_s  = req_b_i[k*DATA_W +: DATA_W];
                sel_op_s = req_op_i[k*3 +: 3];
            end else begin
                sel_a_s  = sel_a_s;
            end
        end
    end

    // The requester just served drops to lowest priority.
    always_comb begin
        if (gnt_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = {ID_W{1'b0}};
        end else begin
            ptr_next_s = gnt_idx_s + ID_W'(1);
        end
    end

    // Scheduler FSM with operand, ID and response registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= IDLE;
            ptr_r        <= {ID_W{1'b0}};
            id_r         <= {ID_W{1'b0}};
            alu_a_o      <= {DATA_W{1'b0}};
            alu_b_o      <= {DATA_W{1'b0}};
            alu_opcode_o <= 3'd0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= {ID_W{1'b0}};
            rsp_result_o <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // A grant implies the handshake: ready mirrors the grant here.
                    if (gnt_any_s) begin
                        alu_a_o      <= sel_a_s;
                        alu_b_o      <= sel_b_s;
                        alu_opcode_o <= sel_op_s;
                        id_r         <= gnt_idx_s;
                        ptr_r        <= ptr_next_s;
                        state_r      <= EXEC;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                EXEC: begin
                    // ALU samples alu_*_o on this edge.
                    state_r <= CAPT;
                end
                CAPT: begin
                    rsp_result_o <= alu_result_i;
                    rsp_id_o     <= id_r;
                    rsp_valid_o  <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched
// Self-checking bench for alu_sched with a behavioural 1-cycle ALU alongside.
// A transaction-level reference tracks each requester's pending operation,
// the round-robin priority, the busy interval after an accept and the pending
// response, and compares the DUT outputs every cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_sched;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N*3-1:0]  req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_result;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [2:0]      alu_opcode;
    logic [W-1:0]    alu_result;

    always #5 clk_i = ~clk_i;

    alu_sched #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_opcode_o (alu_opcode),
        .alu_result_i (alu_result)
    );

    // Registered ALU stand-in next to the scheduler.
    always @(posedge clk_i) alu_result <= alu_model(alu_a, alu_b, opcode_e'(alu_opcode));

    // Requester slots: one pending operation per requester.
    bit         has_op [N];
    logic [7:0] sa [N];
    logic [7:0] sb [N];
    logic [2:0] sop [N];
    bit         auto_reload;
    int         rdy_mode;   // 0: always accept, 1: random, 2: stall
    int         drop_pct;

    // Reference state.
    int         m_ptr, m_cnt, m_id;
    bit         m_pend;
    logic [7:0] m_res, m_a, m_b;
    logic [2:0] m_op;
    int         n_acc, n_rsp, last_id, last_res;
    bit         rsp_seen;
    int         grants[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = ~a;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = ~(a & b);
            default: r = ~(a | b);
        endcase
        return r[7:0];
    endfunction

    task automatic load(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        has_op[k] = 1'b1; sa[k] = a; sb[k] = b; sop[k] = op;
    endtask

    task automatic new_op(input int k);
        load(k, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k]       = has_op[k] && ($urandom_range(0, 99) >= drop_pct);
            req_a[k*W +: W]    = sa[k];
            req_b[k*W +: W]    = sb[k];
            req_op[k*3 +: 3]   = sop[k];
        end
        if (rdy_mode == 0)      rsp_ready = 1'b1;
        else if (rdy_mode == 2) rsp_ready = 1'b0;
        else                    rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // One clock: compare on the falling edge, advance the reference on the rising edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int  g;
        bit  done;
        exp_rdy = '0;
        g = -1;
        @(negedge clk_i);
        if (m_cnt == 0 && !m_pend) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("ready_onehot", ($countones(req_ready) <= 1), 1);
        chk("rsp_valid", rsp_valid, m_pend);
        if (m_pend) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_res);
        end
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_opcode", alu_opcode, m_op);
        done = m_pend && rsp_ready;
        @(posedge clk_i);
        if (done) begin
            m_pend = 1'b0; n_rsp++; last_id = m_id; last_res = m_res; rsp_seen = 1'b1;
        end
        if (g >= 0) begin
            m_a = sa[g]; m_b = sb[g]; m_op = sop[g]; m_id = g;
            m_res = ref_alu(sa[g], sb[g], sop[g]);
            m_ptr = (g + 1) % N;
            m_cnt = 2;
            n_acc++;
            grants.push_back(g);
            has_op[g] = 1'b0;
            if (auto_reload) new_op(g);
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_pend = 1'b1;
        end
        #1 drive();
    endtask

    task automatic run_until_rsp(input int max_cycles);
        rsp_seen = 1'b0;
        for (int c = 0; c < max_cycles && !rsp_seen; c++) step();
        if (!rsp_seen) chk("rsp_timeout", 0, 1);
    endtask

    // Asserts reset immediately (asynchronously), checks cleared outputs, releases.
    task automatic do_reset(input int cycles);
        rst_n_i = 1'b0;
        m_ptr = 0; m_cnt = 0; m_pend = 1'b0; m_id = 0;
        m_a = 8'h00; m_b = 8'h00; m_op = 3'd0; m_res = 8'h00;
        drive();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_op", alu_opcode, 0);
        end
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        drive();
    endtask

    task automatic clear_slots();
        for (int k = 0; k < N; k++) has_op[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, rsp0;
        rst_n_i = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            has_op[k] = 1'b0; sa[k] = 8'h00; sb[k] = 8'h00; sop[k] = 3'd0;
        end
        auto_reload = 1'b0; rdy_mode = 0; drop_pct = 0;
        n_acc = 0; n_rsp = 0;
        do_reset(3);

        // Directed ALU operations through different requesters.
        load(0, 8'h0F, 8'h01, 3'd0); drive(); run_until_rsp(12);
        chk("t1_add_res", last_res, 8'h10); chk("t1_add_id", last_id, 0);
        load(1, 8'h00, 8'h01, 3'd1); drive(); run_until_rsp(12);
        chk("t2_sub_res", last_res, 8'hFF); chk("t2_sub_id", last_id, 1);
        load(2, 8'hA5, 8'h00, 3'd2); drive(); run_until_rsp(12);
        chk("t2_not_res", last_res, 8'h5A); chk("t2_not_id", last_id, 2);
        load(3, 8'hF0, 8'h3C, 3'd6); drive(); run_until_rsp(12);
        chk("t2_nand_res", last_res, 8'hCF); chk("t2_nand_id", last_id, 3);
        load(0, 8'hF0, 8'h3C, 3'd7); drive(); run_until_rsp(12);
        chk("t2_nor_res", last_res, 8'h03); chk("t2_nor_id", last_id, 0);

        // All requesters valid continuously from reset: order 0,1,2,3,0.
        for (int k = 0; k < N; k++) new_op(k);
        auto_reload = 1'b1;
        do_reset(2);
        grants.delete();
        for (int c = 0; c < 24; c++) step();
        if (grants.size() >= 5) begin
            chk("t3_g0", grants[0], 0); chk("t3_g1", grants[1], 1);
            chk("t3_g2", grants[2], 2); chk("t3_g3", grants[3], 3);
            chk("t3_g4", grants[4], 0);
        end else begin
            chk("t3_grant_count", grants.size(), 5);
        end
        auto_reload = 1'b0; clear_slots(); drive();
        for (int c = 0; c < 8; c++) step();

        // Response stall with req3 waiting.
        load(0, 8'h12, 8'h34, 3'd5); drive();
        for (int c = 0; c < 12 && !m_pend; c++) step();
        chk("t4_pending", m_pend, 1);
        load(3, 8'h55, 8'h0F, 3'd3); rdy_mode = 2; drive();
        acc0 = n_acc;
        for (int c = 0; c < 5; c++) step();
        chk("t4_no_accept", n_acc, acc0);
        rdy_mode = 0; drive();
        run_until_rsp(4);
        chk("t4_first_id", last_id, 0); chk("t4_first_res", last_res, 8'h26);
        run_until_rsp(12);
        chk("t4_req3_id", last_id, 3); chk("t4_req3_res", last_res, 8'h05);

        // Reset while an operation is in EXEC.
        load(1, 8'h77, 8'h11, 3'd0); drive();
        for (int c = 0; c < 12 && m_cnt != 2; c++) step();
        chk("t5_in_exec", m_cnt, 2);
        rsp0 = n_rsp;
        clear_slots();
        do_reset(2);
        for (int c = 0; c < 4; c++) step();
        chk("t5_no_rsp", n_rsp, rsp0);
        grants.delete();
        load(2, 8'h01, 8'h02, 3'd4); load(0, 8'h09, 8'h03, 3'd1); drive();
        run_until_rsp(12);
        chk("t5_first_id", last_id, 0); chk("t5_first_res", last_res, 8'h06);
        run_until_rsp(12);
        chk("t5_second_id", last_id, 2); chk("t5_second_res", last_res, 8'h03);

        // Random traffic with random response back-pressure.
        acc0 = n_acc; rsp0 = n_rsp;
        drop_pct = 10; rdy_mode = 1; auto_reload = 1'b1;
        for (int k = 0; k < N; k++) new_op(k);
        drive();
        for (int c = 0; c < 2000; c++) step();
        auto_reload = 1'b0; clear_slots(); rdy_mode = 0; drop_pct = 0; drive();
        for (int c = 0; c < 10; c++) step();
        chk("t6_all_answered", n_rsp - rsp0, n_acc - acc0);
        chk("t6_traffic", (n_acc - acc0) > 100, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
